// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART tick generator: oversample strobe, baud strobe, baud-rate square wave.
// Define UART_BAUD_FRAC_EN to build the fractional accumulator; otherwise periods are integer only.
module uart_baud_gen_frac #(
  parameter int P_SYS_CLK      = 100_000_000,
  parameter int P_DEFAULT_BAUD = 115200,
  parameter int P_OVERSAMPLE   = 16,
  parameter int P_DIV_W        = 16,
  parameter int P_FRAC_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_en,
  input  logic [P_DIV_W-1:0]  i_div_int,
  input  logic [P_FRAC_W-1:0] i_div_frac,
  input  logic                i_div_load,
  output logic                o_os_tick,
  output logic                o_baud_tick,
  output logic                o_u_clk,
  output logic                o_load_pend
);
  localparam int OS_W = $clog2(P_OVERSAMPLE);
  localparam logic [63:0] DEF =
    (64'(P_SYS_CLK) << P_FRAC_W) / (64'(P_DEFAULT_BAUD) * 64'(P_OVERSAMPLE));
  localparam logic [P_DIV_W-1:0] DEF_INT = DEF[P_FRAC_W +: P_DIV_W];
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(P_OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(P_OVERSAMPLE / 2);
  localparam logic [P_DIV_W:0] CNT_ONE = (P_DIV_W + 1)'(1);

  logic               run, tick, baud, u_clk, pend;
  logic [P_DIV_W:0]   cnt;
  logic [OS_W-1:0]    os_cnt;
  logic [P_DIV_W-1:0] act_int, sh_int;
  logic               start, apply, carry, tick_nxt;
  logic [P_DIV_W-1:0] nxt_int;
  logic [P_DIV_W:0]   len;
  logic [OS_W-1:0]    os_nxt;

  // A terminal cycle (tick high) also launches the next period; a load captured on it waits one more period.
  assign start    = i_en && (!run || tick);
  assign apply    = pend && !i_div_load && (!i_en || tick);
  assign nxt_int  = apply ? sh_int : act_int;
  assign len      = {1'b0, nxt_int} + {{P_DIV_W{1'b0}}, carry};
  assign tick_nxt = i_en && !start && (cnt == CNT_ONE);

  always_comb begin
    os_nxt = os_cnt;
    if (!i_en || apply) os_nxt = '0;
    else if (tick_nxt)  os_nxt = os_cnt + 1'b1;
  end

`ifdef UART_BAUD_FRAC_EN
  localparam logic [P_FRAC_W-1:0] DEF_FRAC = DEF[P_FRAC_W-1:0];
  logic [P_FRAC_W-1:0] act_frac, sh_frac, acc, acc_base, frac_add, acc_nxt;

  // Switching divisors restarts the accumulator from zero with the new fraction.
  assign acc_base = apply ? '0 : acc;
  assign frac_add = apply ? sh_frac : act_frac;
  assign {carry, acc_nxt} = {1'b0, acc_base} + {1'b0, frac_add};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_frac <= DEF_FRAC;
      sh_frac  <= '0;
      acc      <= '0;
    end else begin
      if (i_div_load) sh_frac <= i_div_frac;
      if (apply)      act_frac <= sh_frac;
      if (!i_en)      acc <= '0;
      else if (start) acc <= acc_nxt;
    end
  end
`else
  logic unused_frac;
  assign carry       = 1'b0;
  assign unused_frac = ^i_div_frac;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run     <= 1'b0;
      tick    <= 1'b0;
      baud    <= 1'b0;
      u_clk   <= 1'b0;
      pend    <= 1'b0;
      cnt     <= '0;
      os_cnt  <= '0;
      act_int <= DEF_INT;
      sh_int  <= DEF_INT;
    end else begin
      run <= i_en;
      if (i_div_load)
        sh_int <= (i_div_int < P_DIV_W'(2)) ? P_DIV_W'(2) : i_div_int;
      if (apply) begin
        act_int <= sh_int;
        pend    <= 1'b0;
      end else if (i_div_load) begin
        pend <= 1'b1;
      end
      if (!i_en)            cnt <= '0;
      else if (start)       cnt <= len - CNT_ONE;
      else if (cnt != '0)   cnt <= cnt - CNT_ONE;
      os_cnt <= os_nxt;
      tick   <= tick_nxt;
      baud   <= tick_nxt && (os_cnt == OS_LAST);
      u_clk  <= i_en && (os_nxt < OS_HALF);
    end
  end

  assign o_os_tick   = tick && i_en;
  assign o_baud_tick = baud && i_en;
  assign o_u_clk     = u_clk && i_en;
  assign o_load_pend = pend;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac at default parameters; expected periods are
// hand-computed for both builds (UART_BAUD_FRAC_EN defined or not).
module tb_uart_baud_gen_frac;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
`ifdef UART_BAUD_FRAC_EN
  localparam int DEF_BAUD = 868;
`else
  localparam int DEF_BAUD = 864;
`endif

  logic clock = 1'b0;
  logic reset, i_en, i_div_load;
  logic [DIV_W-1:0]  i_div_int;
  logic [FRAC_W-1:0] i_div_frac;
  logic o_os_tick, o_baud_tick, o_u_clk, o_load_pend;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ticks[$];
  int bauds[$];
  bit pend_seen;

  typedef struct {
    int di; int df; int p0; int p1; int p2; int p3; int baud;
  } vec_t;
  vec_t vecs[6];

  uart_baud_gen_frac dut (
    .clock(clock), .reset(reset), .i_en(i_en),
    .i_div_int(i_div_int), .i_div_frac(i_div_frac), .i_div_load(i_div_load),
    .o_os_tick(o_os_tick), .o_baud_tick(o_baud_tick),
    .o_u_clk(o_u_clk), .o_load_pend(o_load_pend)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Default divisor 54 + 4/16: one long period in every four.
  function automatic int def_period(input int k);
`ifdef UART_BAUD_FRAC_EN
    return (k % 4 == 3) ? 55 : 54;
`else
    return 54 + 0 * k;
`endif
  endfunction

  function automatic int tk(input int i);
    return (i < ticks.size()) ? ticks[i] : -99999;
  endfunction

  function automatic int bd(input int i);
    return (i < bauds.size()) ? bauds[i] : -99999;
  endfunction

  task automatic clear_obs();
    ticks.delete();
    bauds.delete();
    pend_seen = 1'b0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (o_os_tick) ticks.push_back(cyc);
      if (o_baud_tick) begin
        bauds.push_back(cyc);
        check("baud_tick coincides with os_tick", int'(o_os_tick), 1);
      end
      if (o_load_pend) pend_seen = 1'b1;
    end
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!o_os_tick && n < 200);
    check({nm, " os_tick seen"}, int'(o_os_tick), 1);
  endtask

  task automatic pulse_load(input int di, input int df);
    i_div_int  = DIV_W'(di);
    i_div_frac = FRAC_W'(df);
    i_div_load = 1'b1;
    @(negedge clock);
    i_div_load = 1'b0;
  endtask

  task automatic wait_apply(input string nm, output int t_app, output int t_tick);
    int n = 0;
    bit tick_at_app = 1'b0;
    t_app  = -1;
    t_tick = -1;
    while (o_load_pend && n < 400) begin
      t_app       = cyc;
      tick_at_app = o_os_tick;
      @(negedge clock);
      n++;
      if (o_os_tick && t_tick < 0) t_tick = cyc;
    end
    check({nm, " load_pend cleared"}, int'(o_load_pend), 0);
    check({nm, " os_tick on apply cycle"}, int'(tick_at_app), 1);
  endtask

  initial begin
    int r, m, bad, t_app, t_tick, r1, f1, r2;
    bit prev;

`ifdef UART_BAUD_FRAC_EN
    vecs[0] = '{10,  8, 10, 11, 10, 11, 168};
    vecs[1] = '{ 1,  0,  2,  2,  2,  2,  32};
    vecs[2] = '{20,  0, 20, 20, 20, 20, 320};
    vecs[3] = '{ 5, 15,  5,  6,  6,  6,  95};
    vecs[4] = '{ 0,  3,  2,  2,  2,  2,  35};
    vecs[5] = '{ 3,  4,  3,  3,  3,  4,  52};
`else
    vecs[0] = '{10,  8, 10, 10, 10, 10, 160};
    vecs[1] = '{ 1,  0,  2,  2,  2,  2,  32};
    vecs[2] = '{20,  0, 20, 20, 20, 20, 320};
    vecs[3] = '{ 5, 15,  5,  5,  5,  5,  80};
    vecs[4] = '{ 0,  3,  2,  2,  2,  2,  32};
    vecs[5] = '{ 3,  4,  3,  3,  3,  3,  48};
`endif

    reset = 1'b1; i_en = 1'b0; i_div_load = 1'b0;
    i_div_int = '0; i_div_frac = '0;
    repeat (3) @(negedge clock);
    check("reset os_tick",   int'(o_os_tick),   0);
    check("reset baud_tick", int'(o_baud_tick), 0);
    check("reset u_clk",     int'(o_u_clk),     0);
    check("reset load_pend", int'(o_load_pend), 0);
    reset = 1'b0;
    @(negedge clock);

    // Default divisor from power-up
    i_en = 1'b1; r = cyc; clear_obs();
    observe(1800);
    check("default first os_tick", tk(0) - r, def_period(0));
    for (int k = 1; k < 8; k++)
      check($sformatf("default period %0d", k), tk(k) - tk(k-1), def_period(k));
    check("default first baud", bd(0) - r, DEF_BAUD);
    check("default baud spacing", bd(1) - bd(0), DEF_BAUD);

    // Enable gap mid-period
    wait_tick("gap sync");
    repeat (20) @(negedge clock);
    i_en = 1'b0; bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (o_os_tick || o_baud_tick || o_u_clk || o_load_pend) bad++;
    end
    check("gap nonzero output samples", bad, 0);
    i_en = 1'b1; r = cyc; clear_obs();
    @(negedge clock);
    check("u_clk high after re-enable", int'(o_u_clk), 1);
    observe(DEF_BAUD + 10);
    check("re-enable first os_tick", tk(0) - r, 54);
    check("re-enable first baud", bd(0) - r, DEF_BAUD);

    // Divisor load table
    for (int v = 0; v < 6; v++) begin
      repeat (7) @(negedge clock);
      pulse_load(vecs[v].di, vecs[v].df);
      check($sformatf("vec%0d load_pend set", v), int'(o_load_pend), 1);
      wait_apply($sformatf("vec%0d", v), t_app, t_tick);
      clear_obs();
      observe(vecs[v].baud + 4);
      check($sformatf("vec%0d period 0", v), tk(0) - t_app, vecs[v].p0);
      check($sformatf("vec%0d period 1", v), tk(1) - tk(0), vecs[v].p1);
      check($sformatf("vec%0d period 2", v), tk(2) - tk(1), vecs[v].p2);
      check($sformatf("vec%0d period 3", v), tk(3) - tk(2), vecs[v].p3);
      check($sformatf("vec%0d first baud", v), bd(0) - t_app, vecs[v].baud);
    end

    // Load captured on a terminal cycle waits for the next terminal
    wait_tick("coincide sync");
    m = cyc;
    pulse_load(20, 0);
    check("coincide load_pend set", int'(o_load_pend), 1);
    wait_apply("coincide", t_app, t_tick);
    check("coincide not applied on own terminal", int'(t_app > m), 1);
    check("coincide applied at following terminal", t_app, t_tick);
    clear_obs();
    observe(45);
    check("coincide period 0", tk(0) - t_app, 20);
    check("coincide period 1", tk(1) - tk(0), 20);

    // Second load while pending wins
    wait_tick("double sync");
    repeat (3) @(negedge clock);
    pulse_load(7, 0);
    repeat (2) @(negedge clock);
    pulse_load(9, 0);
    wait_apply("double", t_app, t_tick);
    clear_obs();
    observe(25);
    check("double period 0", tk(0) - t_app, 9);
    check("double period 1", tk(1) - tk(0), 9);

    // Clamped divisor: u_clk shape
    repeat (3) @(negedge clock);
    pulse_load(1, 0);
    wait_apply("clamp", t_app, t_tick);
    r1 = -1; f1 = -1; r2 = -1; prev = o_u_clk;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (o_u_clk && !prev) begin
        if (r1 < 0) r1 = cyc;
        else if (f1 >= 0 && r2 < 0) r2 = cyc;
      end
      if (!o_u_clk && prev && r1 >= 0 && f1 < 0) f1 = cyc;
      prev = o_u_clk;
    end
    check("clamp u_clk high time", f1 - r1, 16);
    check("clamp u_clk period", r2 - r1, 32);

    // Reset while a load is pending
    pulse_load(10, 8);
    check("pre-reset load_pend", int'(o_load_pend), 1);
    reset = 1'b1; i_en = 1'b0;
    @(negedge clock);
    check("reset clears load_pend", int'(o_load_pend), 0);
    reset = 1'b0;
    @(negedge clock);
    i_en = 1'b1; r = cyc; clear_obs();
    observe(300);
    check("post-reset first os_tick", tk(0) - r, def_period(0));
    for (int k = 1; k < 5; k++)
      check($sformatf("post-reset period %0d", k), tk(k) - tk(k-1), def_period(k));
    check("post-reset no pending load", int'(pend_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
